// File: rtl/uart2sram_pkg.sv
// uart2sram_pkg: shared definitions for the uart2sram path.
// Holds the loader state encoding and the byte/word geometry used by
// uart_sram_loader and byte_packer.
package uart2sram_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    DONE    = 3'd3,
    ERROR   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_sram_loader_byte_packer.sv
// byte_packer: assembles UART bytes little-endian into a 32-bit word.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   clear        drop byte index and held byte (start, abort, load end)
//   collect      loader is in COLLECT: rx bytes go into the word buffer
//   writing      loader is in WRITE: rx bytes go into the hold register
//   drain        write acknowledged, returning to COLLECT this cycle
//   rx_ok        valid byte without frame error
//   rx_data      received byte
//   word         buffer with rx_data as the top byte (valid with word_ready)
//   word_ready   4th byte of a word accepted this cycle
//   hold_full    a byte is parked in the hold register
//   overrun      byte lost this cycle (hold register already full)
module byte_packer
  import uart2sram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              collect,
  input  logic              writing,
  input  logic              drain,
  input  logic              rx_ok,
  input  logic [7:0]        rx_data,
  output logic [WORD_W-1:0] word,
  output logic              word_ready,
  output logic              hold_full,
  output logic              overrun
);

  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] word_q;
  logic [7:0]        hold_q;

  assign word_ready = collect && rx_ok && (idx == IDX_W'(BYTES_PER_WORD - 1));
  assign word       = {rx_data, word_q[WORD_W-9:0]};
  assign overrun    = writing && rx_ok && hold_full;

  // On drain the parked byte (or a byte arriving in the ack cycle itself)
  // lands directly in slot 0, so the first COLLECT cycle already sees idx=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      hold_full <= 1'b0;
    end else if (clear) begin
      idx       <= '0;
      hold_full <= 1'b0;
    end else if (collect && rx_ok) begin
      idx <= idx + IDX_W'(1);
    end else if (writing) begin
      if (drain) begin
        hold_full <= 1'b0;
        if (hold_full || rx_ok) idx <= IDX_W'(1);
      end else if (rx_ok && !hold_full) begin
        hold_full <= 1'b1;
      end
    end
  end

  // NOTE: pure data registers carry no reset; the control bits above
  // (idx, hold_full) decide when their contents are meaningful.
  always_ff @(posedge clk) begin
    if (collect && rx_ok) begin
      word_q[{idx, 3'b000} +: 8] <= rx_data;
    end else if (writing && drain) begin
      if (hold_full)  word_q[7:0] <= hold_q;
      else if (rx_ok) word_q[7:0] <= rx_data;
    end
    if (writing && !drain && rx_ok && !hold_full) hold_q <= rx_data;
  end

endmodule

// File: rtl/uart_sram_loader.sv
// uart_sram_loader: sequences UART receiver bytes into SRAM words.
// Packs bytes little-endian into 32-bit words and writes them to
// consecutive word addresses with a req/ack handshake, stopping after
// LOAD_WORDS words. Frame errors abort the load; lost bytes set overrun.
// Optional macro LOADER_CHECKSUM_EN adds an XOR checksum of written words.
// Ports:
//   clk, rst_n        clock / asynchronous active-low reset
//   start             begin a load from IDLE, DONE or ERROR
//   rx_data/rx_valid  received byte and its one-cycle strobe
//   rx_frame_err      stop-bit error, qualified by rx_valid
//   sram_addr/wdata   write word address and data, stable while sram_we
//   sram_we/sram_ack  write request (held) and acceptance
//   busy              in COLLECT or WRITE
//   done/error/overrun sticky status, cleared by start
//   words_written     acknowledged writes this load
//   checksum          XOR of acknowledged words (LOADER_CHECKSUM_EN only)
module uart_sram_loader
  import uart2sram_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int BASE_ADDR  = 0,
  parameter int LOAD_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_frame_err,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [WORD_W-1:0] sram_wdata,
  output logic              sram_we,
  input  logic              sram_ack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              overrun,
`ifdef LOADER_CHECKSUM_EN
  output logic [WORD_W-1:0] checksum,
`endif
  output logic [ADDR_W:0]   words_written
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LOAD_CNT = (ADDR_W + 1)'(LOAD_WORDS);

  state_t            state;
  logic              active, rx_ok, abort, start_ok, ack_take, last_word;
  logic              clear, drain, word_ready, hold_full, pk_overrun;
  logic [WORD_W-1:0] packed_word;

  assign active    = (state == COLLECT) || (state == WRITE);
  assign rx_ok     = rx_valid && !rx_frame_err;
  assign abort     = active && rx_valid && rx_frame_err;
  assign start_ok  = start && !active;
  // A frame error in the ack cycle wins: the write is abandoned uncounted.
  assign ack_take  = (state == WRITE) && sram_ack && !abort;
  assign last_word = (words_written + 1'b1) == LOAD_CNT;
  assign drain     = ack_take && !last_word;
  assign clear     = start_ok || abort || (ack_take && last_word);

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .collect    (state == COLLECT),
    .writing    (state == WRITE),
    .drain      (drain),
    .rx_ok      (rx_ok),
    .rx_data    (rx_data),
    .word       (packed_word),
    .word_ready (word_ready),
    .hold_full  (hold_full),
    .overrun    (pk_overrun)
  );

  // NOTE: non-blocking assignments throughout so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sram_addr     <= BASE;
      sram_wdata    <= '0;
      sram_we       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      overrun       <= 1'b0;
      words_written <= '0;
`ifdef LOADER_CHECKSUM_EN
      checksum      <= '0;
`endif
    end else begin
      if (pk_overrun) overrun <= 1'b1;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state         <= COLLECT;
            busy          <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
            overrun       <= 1'b0;
            words_written <= '0;
            sram_addr     <= BASE;
`ifdef LOADER_CHECKSUM_EN
            checksum      <= '0;
`endif
          end
        end
        COLLECT: begin
          if (abort) begin
            state <= ERROR;
            busy  <= 1'b0;
            error <= 1'b1;
          end else if (word_ready) begin
            state      <= WRITE;
            sram_we    <= 1'b1;
            sram_wdata <= packed_word;
          end
        end
        WRITE: begin
          if (abort) begin
            state   <= ERROR;
            busy    <= 1'b0;
            sram_we <= 1'b0;
            error   <= 1'b1;
          end else if (ack_take) begin
            sram_we       <= 1'b0;
            sram_addr     <= sram_addr + 1'b1;
            words_written <= words_written + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            checksum      <= checksum ^ sram_wdata;
`endif
            if (last_word) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= COLLECT;
            end
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          sram_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sram_loader.sv
// tb_uart_sram_loader: scenario tasks against a write scoreboard for
// uart_sram_loader (LOAD_WORDS=2, BASE_ADDR=0x100).
module tb_uart_sram_loader;

  localparam int ADDR_W     = 20;
  localparam int BASE_ADDR  = 256;
  localparam int LOAD_WORDS = 2;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic              clk, rst_n, start, rx_valid, rx_frame_err, sram_we, sram_ack;
  logic [7:0]        rx_data;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic              busy, done, error, overrun;
  logic [ADDR_W:0]   words_written;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  uart_sram_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .LOAD_WORDS(LOAD_WORDS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_frame_err  (rx_frame_err),
    .sram_addr     (sram_addr),
    .sram_wdata    (sram_wdata),
    .sram_we       (sram_we),
    .sram_ack      (sram_ack),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .overrun       (overrun),
`ifdef LOADER_CHECKSUM_EN
    .checksum      (checksum),
`endif
    .words_written (words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t               exp_q[$];
  logic [ADDR_W-1:0] next_addr;
  logic [31:0]       exp_sum;
  logic [ADDR_W:0]   exp_ww;
  int                checks = 0;
  int                errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fe);
    rx_data = b; rx_valid = 1'b1; rx_frame_err = fe;
    tick();
    rx_valid = 1'b0; rx_frame_err = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    next_addr = BASE; exp_sum = '0; exp_ww = '0;
  endtask

  // Push the expected write; the request must be up the cycle after byte 4.
  task automatic expect_word(input logic [31:0] w);
    exp_q.push_back('{addr: next_addr, data: w});
    next_addr = next_addr + 1'b1;
    checks++;
    if (sram_we !== 1'b1) begin errors++; $display("FAIL req_latency got %b exp 1", sram_we); end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b0);
    expect_word(w);
  endtask

  // Wait for a request, compare with the scoreboard, stall, then ack.
  task automatic serve(input int stall, input bit inject);
    wr_t e;
    int  n;
    n = 0;
    while (sram_we !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (sram_we !== 1'b1) begin errors++; $display("FAIL req_timeout got we=%b exp 1", sram_we); return; end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL unexpected_write got addr %h exp none", sram_addr); return; end
    e = exp_q.pop_front();
    checks++;
    if (sram_addr !== e.addr) begin errors++; $display("FAIL wr_addr got %h exp %h", sram_addr, e.addr); end
    checks++;
    if (sram_wdata !== e.data) begin errors++; $display("FAIL wr_data got %h exp %h", sram_wdata, e.data); end
    for (int k = 0; k < stall; k++) begin
      if (inject && k == 0)      send_byte(8'hAA, 1'b0);
      else if (inject && k == 1) send_byte(8'hBB, 1'b0);
      else                       tick();
      checks++;
      if (sram_we !== 1'b1 || sram_addr !== e.addr || sram_wdata !== e.data) begin
        errors++;
        $display("FAIL stall_stable got we=%b %h/%h exp 1 %h/%h", sram_we, sram_addr, sram_wdata, e.addr, e.data);
      end
    end
    sram_ack = 1'b1;
    tick();
    sram_ack = 1'b0;
    exp_sum = exp_sum ^ e.data;
    exp_ww  = exp_ww + 1'b1;
    checks++;
    if (sram_we !== 1'b0) begin errors++; $display("FAIL we_drop got %b exp 0", sram_we); end
    checks++;
    if (words_written !== exp_ww) begin errors++; $display("FAIL ww_count got %0d exp %0d", words_written, exp_ww); end
  endtask

  task automatic check_done();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL done_state got done=%b busy=%b exp 1 0", done, busy); end
    checks++;
    if (sram_addr !== next_addr) begin errors++; $display("FAIL end_addr got %h exp %h", sram_addr, next_addr); end
`ifdef LOADER_CHECKSUM_EN
    checks++;
    if (checksum !== exp_sum) begin errors++; $display("FAIL checksum got %h exp %h", checksum, exp_sum); end
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (sram_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL %s_flags got we=%b busy=%b done=%b err=%b ovr=%b exp all 0", tag, sram_we, busy, done, error, overrun);
    end
    checks++;
    if (sram_addr !== BASE || sram_wdata !== 32'h0 || words_written !== '0) begin
      errors++;
      $display("FAIL %s_regs got %h/%h/%0d exp %h/0/0", tag, sram_addr, sram_wdata, words_written, BASE);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_frame_err = 1'b0; rx_data = '0; sram_ack = 1'b0;
    #12;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();
    send_byte(8'h5A, 1'b0);  // ignored outside COLLECT/WRITE
    check_idle_outputs("idle");
  endtask

  task automatic test_basic();
    do_start();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_on_start got %b exp 1", busy); end
    send_word(32'h44332211);
    serve(0, 1'b0);
    checks++;
    if (sram_addr !== BASE + 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL after_word0 got %h busy=%b exp %h 1", sram_addr, busy, BASE + 1'b1);
    end
    send_word(32'h88776655);
    serve(0, 1'b0);
    check_done();
  endtask

  task automatic test_stall_overrun();
    do_start();
    checks++;
    if (done !== 1'b0 || words_written !== '0 || sram_addr !== BASE) begin
      errors++; $display("FAIL restart_clear got done=%b ww=%0d %h exp 0 0 %h", done, words_written, sram_addr, BASE);
    end
    send_word(32'h44332211);
    serve(5, 1'b1);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b exp 1", overrun); end
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0);
    expect_word(32'h030201AA);  // held 0xAA is byte 0, 0xBB lost
    serve(0, 1'b0);
    check_done();
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b exp 1", overrun); end
  endtask

  task automatic test_frame_err();
    do_start();
    send_word(32'h0D0C0B0A);
    serve(0, 1'b0);
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b1);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || sram_we !== 1'b0 || words_written !== 1) begin
      errors++; $display("FAIL frame_err got err=%b busy=%b we=%b ww=%0d exp 1 0 0 1", error, busy, sram_we, words_written);
    end
    for (int i = 0; i < 8; i++) begin
      if (i < 4) send_byte(8'(8'hE0 + i), 1'b0); else tick();
      checks++;
      if (sram_we !== 1'b0) begin errors++; $display("FAIL no_write_after_err got %b exp 0", sram_we); end
    end
    do_start();
    checks++;
    if (error !== 1'b0 || sram_addr !== BASE || busy !== 1'b1) begin
      errors++; $display("FAIL err_restart got err=%b %h busy=%b exp 0 %h 1", error, sram_addr, busy, BASE);
    end
    send_word(32'hDEADBEEF);
    serve(1, 1'b0);
    send_word(32'h01234567);
    serve(0, 1'b0);
    check_done();
  endtask

  task automatic test_abort_in_write();
    do_start();
    send_word(32'hCAFEF00D);
    sram_ack = 1'b1; rx_valid = 1'b1; rx_frame_err = 1'b1; rx_data = 8'h77;
    tick();
    sram_ack = 1'b0; rx_valid = 1'b0; rx_frame_err = 1'b0;
    exp_q.delete();
    checks++;
    if (error !== 1'b1 || sram_we !== 1'b0 || words_written !== '0 || sram_addr !== BASE) begin
      errors++; $display("FAIL abort_write got err=%b we=%b ww=%0d %h exp 1 0 0 %h", error, sram_we, words_written, sram_addr, BASE);
    end
  endtask

  task automatic test_reset_mid();
    do_start();
    send_word(32'h5566AABB);
    #1 rst_n = 1'b0;
    #1 check_idle_outputs("mid_reset");
    exp_q.delete();
    #2 rst_n = 1'b1;
    tick();
    do_start();
    send_word(32'h11111111);
    serve(0, 1'b0);
    send_word(32'h22222222);
    serve(2, 1'b0);
    check_done();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall_overrun();
    test_frame_err();
    test_abort_in_write();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
